// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing blocks: 640x480@60 timing,
// counter widths and the sync polarity helper.
package vga_timing_pkg;

  // 640x480@60 timing on a 25 MHz pixel clock
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Default sync polarity: pulses are active-low
  localparam int DEF_SYNC_NEG = 1;

  // Counter widths
  localparam int HCNT_W     = 11;
  localparam int VCNT_W     = 10;
  localparam int FCNT_W     = 16;
  localparam int TICK_DIV_W = 4;

  // Level driven on a sync pin for a given logical pulse state
  function automatic logic sync_level(input logic active, input logic neg);
    return active ^ neg;
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Pixel-rate divider: wraps 0..CLK_DIV-1 and flags the last count as the
// pixel tick. tick is the same-cycle enable for local counters, pix_tick is
// its registered copy for downstream consumers.
module pixel_tick_div
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick,
  output logic pix_tick
);

  localparam logic [TICK_DIV_W-1:0] DIV_LAST = TICK_DIV_W'(CLK_DIV - 1);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("pixel_tick_div: CLK_DIV must be in 1..16");
  end

  logic [TICK_DIV_W-1:0] div_cnt;

  assign tick = (div_cnt == DIV_LAST);

  // Wrap counter and registered pixel enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      pix_tick <= 1'b0;
    end else begin
      pix_tick <= tick;
      div_cnt  <= tick ? '0 : div_cnt + TICK_DIV_W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Drives the horizontal/vertical counters the
// RGB loader decodes into addresses, plus sync/active flags delayed by one
// pixel so they line up with the loader's registered RGB output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = 1,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_NEG = DEF_SYNC_NEG
) (
  input  logic              clk,
  input  logic              reset,
  output logic [HCNT_W-1:0] count_rgb,
  output logic [VCNT_W-1:0] reset_count_rgb,
  output logic              pix_tick,
  output logic              hsync,
  output logic              vsync,
  output logic              video_active,
  output logic              line_start,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048 || H_TOTAL < 1) begin : g_bad_htotal
    $error("vga_timing_gen: H_TOTAL must be in 1..2048");
  end
  if (V_TOTAL > 1024 || V_TOTAL < 1) begin : g_bad_vtotal
    $error("vga_timing_gen: V_TOTAL must be in 1..1024");
  end

  // Window bounds carry one spare bit so an end bound of 2048/1024 fits
  localparam logic [HCNT_W-1:0] H_LAST   = HCNT_W'(H_TOTAL - 1);
  localparam logic [VCNT_W-1:0] V_LAST   = VCNT_W'(V_TOTAL - 1);
  localparam logic [HCNT_W:0]   H_VIS    = (HCNT_W+1)'(H_ACTIVE);
  localparam logic [HCNT_W:0]   HS_START = (HCNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [HCNT_W:0]   HS_STOP  = (HCNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCNT_W:0]   V_VIS    = (VCNT_W+1)'(V_ACTIVE);
  localparam logic [VCNT_W:0]   VS_START = (VCNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [VCNT_W:0]   VS_STOP  = (VCNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic NEG      = (SYNC_NEG != 0);
  localparam logic SYNC_IDLE = NEG;

  logic tick;

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .pix_tick (pix_tick)
  );

  // Stage p0: decode of the current (pre-update) counter values
  logic h_wrap_p0, v_wrap_p0;
  logic hs_win_p0, vs_win_p0, vis_p0;

  assign h_wrap_p0 = (count_rgb == H_LAST);
  assign v_wrap_p0 = (reset_count_rgb == V_LAST);
  assign hs_win_p0 = ({1'b0, count_rgb} >= HS_START) && ({1'b0, count_rgb} < HS_STOP);
  assign vs_win_p0 = ({1'b0, reset_count_rgb} >= VS_START) &&
                     ({1'b0, reset_count_rgb} < VS_STOP);
  assign vis_p0    = ({1'b0, count_rgb} < H_VIS) && ({1'b0, reset_count_rgb} < V_VIS);

  // Raster counters, frame counter and first-zero strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_rgb       <= '0;
      reset_count_rgb <= '0;
      frame_count     <= '0;
      line_start      <= 1'b0;
      frame_start     <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (tick) begin
        if (h_wrap_p0) begin
          count_rgb  <= '0;
          line_start <= 1'b1;
          if (v_wrap_p0) begin
            reset_count_rgb <= '0;
            frame_count     <= frame_count + FCNT_W'(1);
            frame_start     <= 1'b1;
          end else begin
            reset_count_rgb <= reset_count_rgb + VCNT_W'(1);
          end
        end else begin
          count_rgb <= count_rgb + HCNT_W'(1);
        end
      end
    end
  end

  // Stage p1: sync and active flags registered one pixel behind the counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync        <= SYNC_IDLE;
      vsync        <= SYNC_IDLE;
      video_active <= 1'b0;
    end else if (tick) begin
      hsync        <= sync_level(hs_win_p0, NEG);
      vsync        <= sync_level(vs_win_p0, NEG);
      video_active <= vis_p0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. Four instances share clock and reset:
//   0: default 640x480 timing, CLK_DIV=1
//   1: tiny 15x8 raster, CLK_DIV=1
//   2: same tiny raster, CLK_DIV=4, active-high sync
//   3: 1x1 raster, so frame_count advances every clk and rolls over quickly
// Expected outputs come from an arithmetic model driven by the number of
// clk edges since reset release.
module tb_vga_timing_gen;

  localparam int NI = 4;
  localparam int P_DIV [NI] = '{1, 1, 4, 1};
  localparam int P_HA  [NI] = '{640, 8, 8, 1};
  localparam int P_HFP [NI] = '{16, 2, 2, 0};
  localparam int P_HS  [NI] = '{96, 3, 3, 0};
  localparam int P_HBP [NI] = '{48, 2, 2, 0};
  localparam int P_VA  [NI] = '{480, 4, 4, 1};
  localparam int P_VFP [NI] = '{10, 1, 1, 0};
  localparam int P_VS  [NI] = '{2, 2, 2, 0};
  localparam int P_VBP [NI] = '{33, 1, 1, 0};
  localparam int P_SN  [NI] = '{1, 1, 0, 1};

  logic        clk;
  logic        reset;
  logic [10:0] cnt [NI];
  logic [9:0]  ln  [NI];
  logic        pt  [NI];
  logic        hs  [NI];
  logic        vs  [NI];
  logic        va  [NI];
  logic        ls  [NI];
  logic        fs  [NI];
  logic [15:0] fc  [NI];

  vga_timing_gen u_dut0 (
    .clk             (clk),
    .reset           (reset),
    .count_rgb       (cnt[0]),
    .reset_count_rgb (ln[0]),
    .pix_tick        (pt[0]),
    .hsync           (hs[0]),
    .vsync           (vs[0]),
    .video_active    (va[0]),
    .line_start      (ls[0]),
    .frame_start     (fs[0]),
    .frame_count     (fc[0])
  );

  for (genvar g = 1; g < NI; g++) begin : g_dut
    vga_timing_gen #(
      .CLK_DIV  (P_DIV[g]),
      .H_ACTIVE (P_HA[g]),
      .H_FP     (P_HFP[g]),
      .H_SYNC   (P_HS[g]),
      .H_BP     (P_HBP[g]),
      .V_ACTIVE (P_VA[g]),
      .V_FP     (P_VFP[g]),
      .V_SYNC   (P_VS[g]),
      .V_BP     (P_VBP[g]),
      .SYNC_NEG (P_SN[g])
    ) u_dut (
      .clk             (clk),
      .reset           (reset),
      .count_rgb       (cnt[g]),
      .reset_count_rgb (ln[g]),
      .pix_tick        (pt[g]),
      .hsync           (hs[g]),
      .vsync           (vs[g]),
      .video_active    (va[g]),
      .line_start      (ls[g]),
      .frame_start     (fs[g]),
      .frame_count     (fc[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int unsigned c = 0;   // clk edges seen since reset release

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic check(input string tag, input int i, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst%0d c=%0d got=%0h exp=%0h", tag, i, c, obs, exp);
    end
  endtask

  // Reference: after c edges there have been c/CLK_DIV pixel ticks; the
  // raster position is that tick count folded by line and frame length.
  task automatic model(input int i, input int unsigned cc,
                       output logic [36:0] e_ctr, output logic [2:0] e_stb,
                       output logic [2:0] e_dec);
    int unsigned ht, vt, ft, n, p, h, v;
    logic        idle, tk, hw, vw;
    ht = P_HA[i] + P_HFP[i] + P_HS[i] + P_HBP[i];
    vt = P_VA[i] + P_VFP[i] + P_VS[i] + P_VBP[i];
    ft = ht * vt;
    n  = cc / P_DIV[i];
    e_ctr = {11'(n % ht), 10'((n / ht) % vt), 16'((n / ft) % 65536)};
    tk    = (cc != 0) && (cc % P_DIV[i] == 0);
    e_stb = {tk, tk && (n % ht == 0), tk && (n % ft == 0)};
    idle  = (P_SN[i] != 0);
    if (n == 0) begin
      e_dec = {idle, idle, 1'b0};
    end else begin
      p  = n - 1;
      h  = p % ht;
      v  = (p / ht) % vt;
      hw = (h >= P_HA[i] + P_HFP[i]) && (h < P_HA[i] + P_HFP[i] + P_HS[i]);
      vw = (v >= P_VA[i] + P_VFP[i]) && (v < P_VA[i] + P_VFP[i] + P_VS[i]);
      e_dec = {hw ? ~idle : idle, vw ? ~idle : idle, (h < P_HA[i]) && (v < P_VA[i])};
    end
  endtask

  task automatic check_all();
    logic [36:0] e_ctr;
    logic [2:0]  e_stb, e_dec;
    for (int i = 0; i < NI; i++) begin
      model(i, c, e_ctr, e_stb, e_dec);
      check("counters", i, 64'({cnt[i], ln[i], fc[i]}), 64'(e_ctr));
      check("tick_strobes", i, 64'({pt[i], ls[i], fs[i]}), 64'(e_stb));
      check("sync_active", i, 64'({hs[i], vs[i], va[i]}), 64'(e_dec));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) c++;
    @(negedge clk);
    check_all();
    if (errors >= 50) finish_run();
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before the next edge
  task automatic pulse_reset(input int hold);
    #(1 + $urandom_range(0, 2));
    reset = 1'b1;
    c     = 0;
    #1;
    check_all();
    repeat (hold) step();
    #1 reset = 1'b0;
  endtask

  int hs0_low = 0, va0_hi = 0, ls0_cnt = 0, hs2_act = 0, vs2_act = 0, fs1_cnt = 0;

  initial begin
    reset = 1'b1;
    repeat (3) step();
    #1 reset = 1'b0;

    // Run to count_rgb=300 on the default raster, then reset mid-line
    repeat (300) step();
    checks++;
    assert (cnt[0] === 11'd300) else begin
      errors++;
      $error("FAIL midline_pos inst0 got=%0d exp=300", cnt[0]);
    end
    pulse_reset(2);

    // Random run lengths interrupted by random reset pulses
    repeat (3) begin
      repeat ($urandom_range(50, 800)) step();
      pulse_reset($urandom_range(1, 3));
    end

    // Long uninterrupted run: line/frame wraps, sync widths, frame rollover
    for (int k = 0; k < 65540; k++) begin
      step();
      if (c >= 801 && c <= 1600) begin
        if (hs[0] == 1'b0) hs0_low++;
        if (va[0]) va0_hi++;
        if (ls[0]) ls0_cnt++;
      end
      if (c >= 8 && c <= 487) begin
        if (hs[2]) hs2_act++;
        if (vs[2]) vs2_act++;
      end
      if (c >= 121 && c <= 240 && fs[1]) fs1_cnt++;
      if (c == 65535) begin
        checks++;
        assert (fc[3] === 16'hFFFF) else begin
          errors++;
          $error("FAIL fcount_max inst3 got=%0h exp=ffff", fc[3]);
        end
      end
      if (c == 65536) begin
        checks++;
        assert ({fc[3], fs[3]} === {16'h0000, 1'b1}) else begin
          errors++;
          $error("FAIL fcount_roll inst3 got=%0h/%0b exp=0000/1", fc[3], fs[3]);
        end
      end
    end

    checks++;
    assert (hs0_low == 96) else begin
      errors++;
      $error("FAIL hsync_width inst0 got=%0d exp=96", hs0_low);
    end
    checks++;
    assert (va0_hi == 640) else begin
      errors++;
      $error("FAIL active_width inst0 got=%0d exp=640", va0_hi);
    end
    checks++;
    assert (ls0_cnt == 1) else begin
      errors++;
      $error("FAIL line_start_count inst0 got=%0d exp=1", ls0_cnt);
    end
    checks++;
    assert (hs2_act == 96) else begin
      errors++;
      $error("FAIL hsync_clks_div4 inst2 got=%0d exp=96", hs2_act);
    end
    checks++;
    assert (vs2_act == 120) else begin
      errors++;
      $error("FAIL vsync_clks_div4 inst2 got=%0d exp=120", vs2_act);
    end
    checks++;
    assert (fs1_cnt == 1) else begin
      errors++;
      $error("FAIL frame_start_count inst1 got=%0d exp=1", fs1_cnt);
    end

    finish_run();
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing for the display pipeline. Sits directly upstream of the pixel RGB loader stage.
- Drives the horizontal pixel counter (count_rgb) and vertical line counter (reset_count_rgb) that the loader decodes into pixel addresses.
- Produces hsync/vsync and video_active, delayed to line up with the loader's registered RGB output, plus frame/line strobes for resetting downstream address counters.
- Default timing is 640x480@60 on a 25 MHz pixel tick.

Parameters:
CLK_DIV, 1, clk cycles per pixel tick (1..16); 1 = every clk is a pixel
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_NEG, 1, 1 = sync pulses active-low

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
count_rgb  out  11  horizontal counter, 0..H_TOTAL-1
reset_count_rgb  out  10  vertical counter, 0..V_TOTAL-1
pix_tick  out  1  one-clk pixel enable
hsync  out  1  horizontal sync, polarity per SYNC_NEG
vsync  out  1  vertical sync, polarity per SYNC_NEG
video_active  out  1  high when the pixel now on the RGB bus is visible
line_start  out  1  one-clk pulse when count_rgb becomes 0
frame_start  out  1  one-clk pulse when both counters become 0
frame_count  out  16  completed-frame counter

Behaviour:
- Derived values:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, default 800.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, default 525.
  - Elaboration error if H_TOTAL > 2048 or V_TOTAL > 1024.
- Reset (async assert, sync release):
  - count_rgb=0, reset_count_rgb=0, divider=0, frame_count=0.
  - pix_tick=0, line_start=0, frame_start=0, video_active=0.
  - hsync and vsync at inactive level (1 when SYNC_NEG=1).
- Reset mid-frame returns every output to the values above within the same cycle. Counting restarts at (0,0) with no frame_start pulse.
- Divider:
  - 0..CLK_DIV-1 wrap counter.
  - pix_tick is registered and high for the one clk after the divider reaches CLK_DIV-1.
  - CLK_DIV=1: pix_tick=1 on every clk from the first edge after reset release.
- Counter update, on each clk where the internal tick fires:
  - count_rgb increments; at H_TOTAL-1 it wraps to 0.
  - On that wrap, reset_count_rgb increments; at V_TOTAL-1 it wraps to 0.
  - On a vertical wrap, frame_count increments (mod 2^16).
  - All counters hold between ticks.
- Strobes:
  - line_start=1 for exactly the one clk in which count_rgb first shows 0.
  - frame_start=1 in the clk in which both counters first show (0,0), i.e. after reset_count_rgb=V_TOTAL-1, count_rgb=H_TOTAL-1.
- Decode, taken from the counter values before the update and registered on the same tick (one-pixel delay):
  - hsync active iff H_ACTIVE+H_FP <= count < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync active iff V_ACTIVE+V_FP <= line < V_ACTIVE+V_FP+V_SYNC (490..491).
  - video_active iff count<H_ACTIVE and line<V_ACTIVE.
  - Result: sync and active flags are aligned with the loader's registered RGB output.
- Loader constraint: the RGB loader advances its address on every clk, so this block must run with CLK_DIV=1 when driving it. Other consumers gate on pix_tick.
- Counters and decode are fully synchronous; no combinational path from reset to outputs other than the async clear.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 timing constants (H_ACTIVE..V_BP).
  - Counter widths HCNT_W=11 and VCNT_W=10.
  - Sync polarity constant.
- Sub-module pixel_tick_div contains the CLK_DIV divider with pix_tick output. It is reused by the future SVGA timing variant.

Test Plan:
- Reset check: assert reset mid-line at count_rgb=300 -> same cycle all outputs hold reset values and hsync=vsync=1; after release count_rgb=0,1,2... with CLK_DIV=1 and no frame_start pulse.
- Line wrap: CLK_DIV=1, run to count_rgb=799 -> next clk count_rgb=0, reset_count_rgb +1, line_start=1 for exactly one clk.
- Hsync timing: scan one line -> hsync low exactly when the previous-clk count was 656..751 (96 clks, one clk after count reaches 656); video_active high for 640 clks, lagging count by one clk.
- Frame wrap: run to (799,524) -> next clk counters (0,0), frame_start=1 for one clk, frame_count=1; vsync low for 1600 clks covering lines 490..491, one-clk lagged.
- Divider: CLK_DIV=4 -> pix_tick every 4th clk; counters change only on ticks; hsync width = 384 clks; frame length = 1,680,000 clks.
- Frame counter rollover: force frame_count to 0xFFFF, complete one frame -> frame_count=0x0000, frame_start pulses normally.
